// File: rtl/point_referee.sv
// point_referee: scores ball landings per half-court, pauses after each point,
// serves the next rally and declares the match over at WIN_SCORE.
module point_referee #(
    parameter logic [11:0] GROUND_Y     = 12'd700,
    parameter logic [11:0] NET_X        = 12'd512,
    parameter logic [3:0]  WIN_SCORE    = 4'd15,
    parameter logic [7:0]  PAUSE_FRAMES = 8'd60
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] ball_xpos,
    input  logic [11:0] ball_ypos,
    input  logic        new_game,
    output logic [3:0]  score_pl1,
    output logic [3:0]  score_pl2,
    output logic        last_touch,
    output logic        endgame,
    output logic        freeze,
    output logic        serve_req,
    output logic        serve_side
);
    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

    state_t      r_state, w_state;
    logic        r_arm, w_arm;
    logic [7:0]  r_cnt, w_cnt;
    logic [3:0]  r_s1, r_s2, w_s1, w_s2;
    logic        r_last, w_last;
    logic        r_serve_req, w_serve_req;
    logic        r_serve_side, w_serve_side;
    logic        r_freeze, r_endgame;

    always_comb begin
        w_state      = r_state;
        w_arm        = r_arm;
        w_cnt        = r_cnt;
        w_s1         = r_s1;
        w_s2         = r_s2;
        w_last       = r_last;
        w_serve_req  = 1'b0;
        w_serve_side = r_serve_side;
        if (new_game) begin
            // restart serves immediately; SERVE then only retires the pulse
            w_state      = SERVE;
            w_arm        = 1'b0;
            w_cnt        = 8'd0;
            w_s1         = 4'd0;
            w_s2         = 4'd0;
            w_last       = 1'b0;
            w_serve_req  = 1'b1;
            w_serve_side = 1'b0;
        end else begin
            case (r_state)
                SERVE: begin
                    w_serve_req  = !r_serve_req;
                    w_serve_side = r_serve_req ? r_serve_side : r_last;
                    w_arm        = 1'b0;
                    w_state      = PLAY;
                end
                PLAY: begin
                    if (frame_tick && !r_arm)
                        w_arm = 1'b1;
                    else if (frame_tick && ball_ypos >= GROUND_Y) begin
                        w_state = POINT;
                        w_cnt   = 8'd0;
                        w_last  = ball_xpos < NET_X;
                        w_s1    = (ball_xpos >= NET_X && r_s1 < WIN_SCORE) ? r_s1 + 4'd1 : r_s1;
                        w_s2    = (ball_xpos <  NET_X && r_s2 < WIN_SCORE) ? r_s2 + 4'd1 : r_s2;
                    end
                end
                POINT: begin
                    if (frame_tick && r_cnt == PAUSE_FRAMES - 8'd1) begin
                        w_cnt   = 8'd0;
                        w_state = (r_s1 == WIN_SCORE || r_s2 == WIN_SCORE) ? OVER : SERVE;
                    end else if (frame_tick)
                        w_cnt = r_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_state      <= SERVE;
            r_arm        <= 1'b0;
            r_cnt        <= 8'd0;
            r_s1         <= 4'd0;
            r_s2         <= 4'd0;
            r_last       <= 1'b0;
            r_serve_req  <= 1'b0;
            r_serve_side <= 1'b0;
            r_freeze     <= 1'b0;
            r_endgame    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_arm        <= w_arm;
            r_cnt        <= w_cnt;
            r_s1         <= w_s1;
            r_s2         <= w_s2;
            r_last       <= w_last;
            r_serve_req  <= w_serve_req;
            r_serve_side <= w_serve_side;
            r_freeze     <= w_state == POINT || w_state == OVER;
            r_endgame    <= w_state == OVER;
        end
    end

    assign score_pl1  = r_s1;
    assign score_pl2  = r_s2;
    assign last_touch = r_last;
    assign endgame    = r_endgame;
    assign freeze     = r_freeze;
    assign serve_req  = r_serve_req;
    assign serve_side = r_serve_side;
endmodule

// File: tb/tb_point_referee.sv
// tb_point_referee: directed checks of scoring, pause, serve, game over,
// new_game priority and reset abort.
module tb_point_referee;
    logic        clk = 1'b0;
    logic        rst, frame_tick, new_game;
    logic [11:0] ball_xpos, ball_ypos;
    logic [3:0]  score_pl1, score_pl2;
    logic        last_touch, endgame, freeze, serve_req, serve_side;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    point_referee dut (
        .clk65MHz(clk), .rst(rst), .frame_tick(frame_tick),
        .ball_xpos(ball_xpos), .ball_ypos(ball_ypos), .new_game(new_game),
        .score_pl1(score_pl1), .score_pl2(score_pl2), .last_touch(last_touch),
        .endgame(endgame), .freeze(freeze), .serve_req(serve_req), .serve_side(serve_side)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    // 60-tick pause, serve, arm tick, landing tick
    task automatic point_round();
        tick(60);
        tick(1);
        tick(1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_s1"}, int'(score_pl1), 0);
        chk({tag, "_s2"}, int'(score_pl2), 0);
        chk({tag, "_last"}, int'(last_touch), 0);
        chk({tag, "_endgame"}, int'(endgame), 0);
        chk({tag, "_freeze"}, int'(freeze), 0);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; new_game = 1'b0;
        ball_xpos = 12'd0; ball_ypos = 12'd0;
        cyc(3);
        chk_idle("reset");
        chk("reset_serve_req", int'(serve_req), 0);
        chk("reset_serve_side", int'(serve_side), 0);

        rst = 1'b0;
        cyc(1);
        chk("first_serve_req", int'(serve_req), 1);
        chk("first_serve_side", int'(serve_side), 0);
        cyc(1);
        chk("serve_pulse_one_cycle", int'(serve_req), 0);
        chk("play_freeze", int'(freeze), 0);

        ball_xpos = 12'd300; ball_ypos = 12'd700;
        tick(1);
        chk("arm_tick_no_score", int'(score_pl2), 0);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("land_left_s2", int'(score_pl2), 1);
        chk("land_left_last", int'(last_touch), 1);
        chk("land_left_freeze", int'(freeze), 1);
        tick(59);
        chk("pause59_freeze", int'(freeze), 1);
        chk("pause59_no_serve", int'(serve_req), 0);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("pause_end_unfreeze", int'(freeze), 0);
        cyc(1);
        chk("serve_after_p2", int'(serve_req), 1);
        chk("serve_side_p2", int'(serve_side), 1);

        ball_xpos = 12'd800; ball_ypos = 12'd720;
        tick(1);
        chk("rest_arm_no_score", int'(score_pl1), 0);
        tick(1);
        chk("land_right_s1", int'(score_pl1), 1);
        chk("land_right_last", int'(last_touch), 0);
        tick(60);
        chk("rest_serve_req", int'(serve_req), 1);
        chk("rest_serve_side", int'(serve_side), 0);
        chk("rest_no_reinc", int'(score_pl1), 1);
        tick(1);
        chk("rest_arm_no_reinc", int'(score_pl1), 1);
        tick(1);
        chk("rest_next_point", int'(score_pl1), 2);

        repeat (12) point_round();
        chk("run_to_14", int'(score_pl1), 14);
        chk("p2_held", int'(score_pl2), 1);
        ball_xpos = 12'd512;
        point_round();
        chk("net_edge_s1", int'(score_pl1), 15);
        chk("net_edge_last", int'(last_touch), 0);
        chk("pre_over_endgame", int'(endgame), 0);
        tick(60);
        chk("over_endgame", int'(endgame), 1);
        chk("over_freeze", int'(freeze), 1);
        chk("over_no_serve", int'(serve_req), 0);
        ball_xpos = 12'd100;
        tick(3);
        chk("over_hold_s1", int'(score_pl1), 15);
        chk("over_hold_s2", int'(score_pl2), 1);

        ball_ypos = 12'd750;
        new_game = 1'b1; frame_tick = 1'b1;
        cyc(1);
        new_game = 1'b0; frame_tick = 1'b0;
        chk_idle("new_game");
        chk("new_game_serve_req", int'(serve_req), 1);
        chk("new_game_serve_side", int'(serve_side), 0);
        cyc(1);
        chk("new_game_pulse_one", int'(serve_req), 0);

        tick(1);
        new_game = 1'b1; frame_tick = 1'b1;
        cyc(1);
        new_game = 1'b0; frame_tick = 1'b0;
        chk("ng_priority_s2", int'(score_pl2), 0);
        chk("ng_priority_freeze", int'(freeze), 0);
        cyc(1);

        tick(2);
        chk("p2_first", int'(score_pl2), 1);
        repeat (4) point_round();
        chk("p2_five", int'(score_pl2), 5);
        tick(30);
        chk("mid_pause_freeze", int'(freeze), 1);
        rst = 1'b1;
        cyc(1);
        chk_idle("abort");
        chk("abort_serve_req", int'(serve_req), 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("abort_serve_req_after", int'(serve_req), 1);
        chk("abort_serve_side_after", int'(serve_side), 0);
        chk("abort_s2_after", int'(score_pl2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
